// File: rtl/copy_eng_pkg.sv
// Shared channel definitions for the copy engine: FSM states, op codes and
// helpers that build the checksum and the end-of-job marker word.
package copy_eng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_XFER  = 3'd2,
        ST_MARK  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_COPY  = 2'b00;
    localparam logic [1:0] OP_INV   = 2'b01;
    localparam logic [1:0] OP_BSWAP = 2'b10;

    localparam int WCNT_W = 16;
    localparam int CSUM_W = 32;

    function automatic logic [CSUM_W-1:0] fold64(input logic [63:0] w);
        return w[63:32] ^ w[31:0];
    endfunction

    function automatic logic [63:0] marker(input logic [CSUM_W-1:0] csum,
                                           input logic [WCNT_W-1:0] wcnt);
        return {csum, 16'h0, wcnt};
    endfunction

endpackage

// File: rtl/copy_op.sv
// Combinational word transform applied on the way from source to destination:
// copy, bitwise invert or byte reverse; the spare op code behaves as copy.
module copy_op
    import copy_eng_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    // NOTE: dout gets a default before the case so no op value can infer a latch.
    always_comb begin
        dout = din;
        case (op)
            OP_COPY:  dout = din;
            OP_INV:   dout = ~din;
            OP_BSWAP: begin
                for (int i = 0; i < 8; i++) begin
                    dout[8*i +: 8] = din[8*(7-i) +: 8];
                end
            end
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/copy_eng.sv
// Single-channel FIFO-to-FIFO copy engine: moves words through copy_op, keeps a
// word count and XOR checksum, and closes each job with a marker word.
module copy_eng
    import copy_eng_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [23:0]   dc1,
    output logic          m_reset1,
    output logic          m_src_getn1,
    input  logic [DW-1:0] m_src1,
    input  logic          m_src_last1,
    input  logic          m_src_empty1,
    input  logic          m_src_almost_empty1,
    output logic          m_dst_putn1,
    output logic [DW-1:0] m_dst1,
    output logic          m_dst_last1,
    input  logic          m_dst_almost_full1,
    input  logic          m_dst_full1,
    output logic          m_endn1,
    output logic          err1
);

    state_t            state;
    state_t            state_nx;
    logic              en;
    logic              settled;
    logic              mark_push;
    logic              push;
    logic [1:0]        op_q;
    logic [WCNT_W-1:0] wcnt;
    logic [CSUM_W-1:0] csum;
    logic [63:0]       xfer_word;
    logic              unused_inputs;

    assign en            = dc1[0];
    assign unused_inputs = ^{m_src_almost_empty1, dc1[23:3]};

    copy_op u_copy_op (
        .op   (op_q),
        .din  (m_src1),
        .dout (xfer_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // settled is low on the first FETCH cycle, giving the source RAM one cycle
    // to present the word at the freshly changed read address.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (en) state_nx = ST_FETCH;
            ST_FETCH: begin
                if (!en)                                                   state_nx = ST_IDLE;
                else if (settled && !m_src_empty1 && !m_dst_almost_full1) state_nx = ST_XFER;
            end
            ST_XFER: begin
                if (!en)              state_nx = ST_IDLE;
                else if (m_src_last1) state_nx = ST_MARK;
                else                  state_nx = ST_FETCH;
            end
            ST_MARK: begin
                if (!en)                     state_nx = ST_IDLE;
                else if (!m_dst_almost_full1) state_nx = ST_DONE;
            end
            ST_DONE:  if (!en) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mark_push   = (state == ST_MARK) && en && !m_dst_almost_full1;
        push        = (state == ST_XFER) || mark_push;
        m_reset1    = (state == ST_IDLE);
        m_src_getn1 = (state != ST_XFER);
        m_dst_putn1 = !push;
        m_dst_last1 = mark_push;
        m_endn1     = (state != ST_DONE);
        m_dst1      = '0;
        if (state == ST_XFER)      m_dst1 = xfer_word;
        else if (state == ST_MARK) m_dst1 = marker(csum, wcnt);
    end

    // Job bookkeeping is cleared while idle, so every job starts from zero.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            settled <= 1'b0;
            op_q    <= OP_COPY;
            wcnt    <= '0;
            csum    <= '0;
            err1    <= 1'b0;
        end else begin
            settled <= (state == ST_FETCH);
            if (state == ST_IDLE) begin
                wcnt <= '0;
                csum <= '0;
                err1 <= 1'b0;
                if (en) op_q <= dc1[2:1];
            end else begin
                if (state == ST_XFER) begin
                    wcnt <= wcnt + WCNT_W'(1);
                    csum <= csum ^ fold64(xfer_word);
                end
                if (push && m_dst_full1) err1 <= 1'b1;
            end
        end
    end

endmodule
